// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI register-write master.
package spi_master_pkg;

  localparam int unsigned FRAME_BITS     = 32;
  localparam int unsigned RSP_BITS       = 16;
  localparam int unsigned WRITE_FLAG_BIT = 31;
  localparam int unsigned REG_BITS       = 15;
  localparam int unsigned VALUE_BITS     = 16;
  localparam int unsigned CMD_BITS       = REG_BITS + VALUE_BITS;
  localparam int unsigned BIT_CNT_BITS   = 6;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    HOLD,
    GAP
  } spiState_t;

  typedef struct packed {
    logic [REG_BITS-1:0]   regnum;
    logic [VALUE_BITS-1:0] value;
  } spiCmd_t;

  // Write flag on top, then register number, then value.
  function automatic logic [FRAME_BITS-1:0] buildFrame(input spiCmd_t cmd);
    return {1'b1, cmd.regnum, cmd.value};
  endfunction

endpackage

// File: rtl/spi_cmd_fifo.sv
// Synchronous command FIFO (power-of-2 depth) holding pending register writes.
module spi_cmd_fifo
  import spi_master_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         i_Clock,
  input  logic                         i_Reset,
  input  logic                         i_Push,
  input  spiCmd_t                      i_Data,
  input  logic                         i_Pop,
  output spiCmd_t                      o_Data,
  output logic                         o_Empty,
  output logic                         o_Full,
  output logic [$clog2(DEPTH+1)-1:0]   o_Count
);

  localparam int unsigned PTR_BITS = $clog2(DEPTH);
  localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);

  spiCmd_t             mem [DEPTH];
  logic [PTR_BITS-1:0] wrPtr;
  logic [PTR_BITS-1:0] rdPtr;
  logic [CNT_BITS-1:0] count;
  logic [CNT_BITS-1:0] countNext;
  logic                doPush;
  logic                doPop;

  assign doPush    = i_Push && !o_Full;
  assign doPop     = i_Pop && !o_Empty;
  assign countNext = count + CNT_BITS'(doPush) - CNT_BITS'(doPop);
  assign o_Data    = mem[rdPtr];
  assign o_Count   = count;

  // Storage array, no reset needed.
  always_ff @(posedge i_Clock) begin
    if (doPush) begin
      mem[wrPtr] <= i_Data;
    end
  end

  // Pointers, occupancy and registered flags.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
      o_Empty <= 1'b1;
      o_Full  <= 1'b0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (doPop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      count   <= countNext;
      o_Empty <= (countNext == '0);
      o_Full  <= (countNext == CNT_BITS'(DEPTH));
    end
  end

endmodule

// File: rtl/spi_register_master.sv
// SPI mode-0 register-write initiator: 32-bit MSB-first frames, 16-bit MISO capture.
// Optional command FIFO enabled by defining SPI_MASTER_CMD_FIFO_EN; otherwise a
// single command is taken straight into the shift register while idle.
module spi_register_master #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned CS_GAP_CYCLES = 8,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_CmdValid,
  output logic        o_CmdReady,
  input  logic [14:0] i_CmdRegNumber,
  input  logic [15:0] i_CmdValue,
  output logic        o_RspValid,
  output logic [15:0] o_RspSample,
  output logic        o_Busy,
  output logic        o_SPI_NSS,
  output logic        o_SPI_SCK,
  output logic        o_SPI_MOSI,
  input  logic        i_SPI_MISO
);

  import spi_master_pkg::*;

  localparam int unsigned DIV_BITS = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GAP_BITS = $clog2(CS_GAP_CYCLES + 1);

  // Elaboration-time parameter legality.
  if (CLK_DIV < 2) begin : g_badClkDiv
    $error("CLK_DIV must be >= 2");
  end
  if (CS_GAP_CYCLES < 1) begin : g_badGap
    $error("CS_GAP_CYCLES must be >= 1");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_badDepth
    $error("FIFO_DEPTH must be a power of 2, >= 2");
  end

  spiState_t               state;
  spiState_t               stateNext;
  logic [DIV_BITS-1:0]     divCnt;
  logic [DIV_BITS-1:0]     divCntNext;
  logic [GAP_BITS-1:0]     gapCnt;
  logic [GAP_BITS-1:0]     gapCntNext;
  logic [BIT_CNT_BITS-1:0] bitCnt;
  logic [BIT_CNT_BITS-1:0] bitCntNext;
  logic [FRAME_BITS-1:0]   shiftReg;
  logic [FRAME_BITS-1:0]   shiftNext;
  logic [FRAME_BITS-1:0]   frameIn;
  logic [RSP_BITS-1:0]     capture;
  logic [RSP_BITS-1:0]     captureNext;
  logic [RSP_BITS-1:0]     rspSampleNext;
  logic                    rspValidNext;
  logic                    nssNext;
  logic                    sckNext;
  logic                    mosiNext;
  logic                    busyNext;
  logic                    divLast;
  logic                    cmdAvail;
  logic                    pendingNext;
  spiCmd_t                 cmdIn;

`ifdef SPI_MASTER_CMD_FIFO_EN
  localparam int unsigned FCNT_BITS = $clog2(FIFO_DEPTH + 1);

  spiCmd_t                fifoHead;
  logic                   fifoEmpty;
  logic                   fifoFull;
  logic                   fifoPush;
  logic                   fifoPop;
  logic [FCNT_BITS-1:0]   fifoCount;
  logic [FCNT_BITS-1:0]   fifoCountNext;

  assign fifoPush      = i_CmdValid && !fifoFull;
  assign fifoPop       = (state == IDLE) && !fifoEmpty;
  assign fifoCountNext = fifoCount + FCNT_BITS'(fifoPush) - FCNT_BITS'(fifoPop);
  assign pendingNext   = (fifoCountNext != '0);
  assign cmdAvail      = !fifoEmpty;
  assign cmdIn         = fifoHead;
  assign o_CmdReady    = !fifoFull;

  spi_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_cmdFifo (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Push  (fifoPush),
    .i_Data  ({i_CmdRegNumber, i_CmdValue}),
    .i_Pop   (fifoPop),
    .o_Data  (fifoHead),
    .o_Empty (fifoEmpty),
    .o_Full  (fifoFull),
    .o_Count (fifoCount)
  );
`else
  logic cmdReadyReg;

  assign pendingNext = 1'b0;
  assign cmdAvail    = i_CmdValid && cmdReadyReg;
  assign cmdIn       = {i_CmdRegNumber, i_CmdValue};
  assign o_CmdReady  = cmdReadyReg;

  // Ready only while the next state is IDLE, so a held command goes out once.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      cmdReadyReg <= 1'b1;
    end else begin
      cmdReadyReg <= (stateNext == IDLE);
    end
  end
`endif

  assign frameIn = buildFrame(cmdIn);
  assign divLast = (divCnt == DIV_BITS'(CLK_DIV - 1));

  // State and datapath registers.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state       <= IDLE;
      divCnt      <= '0;
      gapCnt      <= '0;
      bitCnt      <= '0;
      shiftReg    <= '0;
      capture     <= '0;
      o_SPI_NSS   <= 1'b1;
      o_SPI_SCK   <= 1'b0;
      o_SPI_MOSI  <= 1'b0;
      o_RspValid  <= 1'b0;
      o_RspSample <= '0;
      o_Busy      <= 1'b0;
    end else begin
      state       <= stateNext;
      divCnt      <= divCntNext;
      gapCnt      <= gapCntNext;
      bitCnt      <= bitCntNext;
      shiftReg    <= shiftNext;
      capture     <= captureNext;
      o_SPI_NSS   <= nssNext;
      o_SPI_SCK   <= sckNext;
      o_SPI_MOSI  <= mosiNext;
      o_RspValid  <= rspValidNext;
      o_RspSample <= rspSampleNext;
      o_Busy      <= busyNext;
    end
  end

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    stateNext     = state;
    divCntNext    = divCnt;
    gapCntNext    = gapCnt;
    bitCntNext    = bitCnt;
    shiftNext     = shiftReg;
    captureNext   = capture;
    mosiNext      = o_SPI_MOSI;
    rspValidNext  = 1'b0;
    rspSampleNext = o_RspSample;

    case (state)
      IDLE: begin
        if (cmdAvail) begin
          shiftNext   = frameIn;
          mosiNext    = frameIn[WRITE_FLAG_BIT];
          divCntNext  = '0;
          bitCntNext  = '0;
          captureNext = '0;
          stateNext   = SETUP;
        end
      end
      SETUP: begin
        if (divLast) begin
          divCntNext = '0;
          stateNext  = SHIFT_HI;
        end else begin
          divCntNext = divCnt + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (divLast) begin
          divCntNext = '0;
          // Only the first 16 rising edges carry the returned sample.
          if (bitCnt < BIT_CNT_BITS'(RSP_BITS)) begin
            captureNext = {capture[RSP_BITS-2:0], i_SPI_MISO};
          end
          bitCntNext = bitCnt + 1'b1;
          shiftNext  = {shiftReg[FRAME_BITS-2:0], 1'b0};
          mosiNext   = shiftReg[FRAME_BITS-2];
          stateNext  = SHIFT_LO;
        end else begin
          divCntNext = divCnt + 1'b1;
        end
      end
      SHIFT_LO: begin
        if (divLast) begin
          divCntNext = '0;
          stateNext  = (bitCnt == BIT_CNT_BITS'(FRAME_BITS)) ? HOLD : SHIFT_HI;
        end else begin
          divCntNext = divCnt + 1'b1;
        end
      end
      HOLD: begin
        if (divLast) begin
          divCntNext    = '0;
          gapCntNext    = '0;
          mosiNext      = 1'b0;
          rspSampleNext = capture;
          rspValidNext  = 1'b1;
          stateNext     = GAP;
        end else begin
          divCntNext = divCnt + 1'b1;
        end
      end
      GAP: begin
        if (gapCnt >= GAP_BITS'(CS_GAP_CYCLES - 1)) begin
          stateNext = IDLE;
        end else begin
          gapCntNext = gapCnt + 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
        mosiNext  = 1'b0;
      end
    endcase

    nssNext  = (stateNext == IDLE) || (stateNext == GAP);
    sckNext  = (stateNext == SHIFT_HI);
    busyNext = (stateNext != IDLE) || pendingNext;
  end

endmodule

// File: tb/tb_spi_register_master.sv
// Scoreboard bench for spi_register_master: SPI slave model, frame and response monitors.
module tb_spi_register_master;

  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 8;
  localparam int NSS_LOW = 66 * CLK_DIV;
  localparam int TIMEOUT = 4000;
  localparam int NV      = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmdValid = 1'b0;
  logic [14:0] cmdReg = '0;
  logic [15:0] cmdVal = '0;
  logic        miso = 1'b0;
  logic        cmdReady;
  logic        rspValid;
  logic [15:0] rspSample;
  logic        busy;
  logic        nss;
  logic        sck;
  logic        mosi;

  spi_register_master #(
    .CLK_DIV       (CLK_DIV),
    .CS_GAP_CYCLES (CS_GAP),
    .FIFO_DEPTH    (4)
  ) dut (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .i_CmdValid     (cmdValid),
    .o_CmdReady     (cmdReady),
    .i_CmdRegNumber (cmdReg),
    .i_CmdValue     (cmdVal),
    .o_RspValid     (rspValid),
    .o_RspSample    (rspSample),
    .o_Busy         (busy),
    .o_SPI_NSS      (nss),
    .o_SPI_SCK      (sck),
    .o_SPI_MOSI     (mosi),
    .i_SPI_MISO     (miso)
  );

  always #5 clk = ~clk;

  // Hand-computed vectors: frame = {1, reg, value}.
  logic [14:0] vReg   [NV] = '{15'h0003, 15'h4005, 15'h7FFF, 15'h0000, 15'h2A55};
  logic [15:0] vVal   [NV] = '{16'h1234, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h5AA5};
  logic [31:0] vFrame [NV] = '{32'h80031234, 32'hC0057FFF, 32'hFFFFFFFF, 32'h80000000, 32'hAA555AA5};
  logic [15:0] vMiso  [NV] = '{16'h1234, 16'hA5C3, 16'h0001, 16'h8000, 16'hFFFE};

  logic [31:0] expFrameQ [$];
  logic [15:0] expRspQ   [$];
  logic [31:0] misoQ     [$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Frame monitor and slave model state.
  int          cyc = 0;
  int          lastNssRiseCyc = 0;
  int          monRise = 0;
  int          nssLow = 0;
  int          gapCnt = 0;
  int          lastRise = 0;
  int          periodErr = 0;
  int          readyHigh = 0;
  int          misoIdx = 0;
  bit          inFrame = 0;
  bit          haveGap = 0;
  logic        prevNss = 1'b1;
  logic        prevSck = 1'b0;
  logic [31:0] capFrame = '0;
  logic [31:0] misoWord = '0;

  // Watch NSS/SCK/MOSI, drive MISO on falling SCK, score each completed frame.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      inFrame = 0;
      haveGap = 0;
      monRise = 0;
      miso    = 1'b0;
    end else begin
      if (!nss && prevNss) begin
        if (haveGap) check("cs_gap_min", 32'(gapCnt >= CS_GAP), 1);
        check("busy_at_frame_start", busy, 1);
        inFrame   = 1;
        monRise   = 0;
        nssLow    = 0;
        capFrame  = '0;
        periodErr = 0;
        readyHigh = 0;
        lastRise  = 0;
        misoWord  = (misoQ.size() > 0) ? misoQ.pop_front() : 32'hFFFF_FFFF;
        miso      = misoWord[31];
        misoIdx   = 30;
      end
      if (inFrame && !nss) begin
        nssLow++;
        if (sck && !prevSck) begin
          monRise++;
          capFrame = {capFrame[30:0], mosi};
          if (monRise > 1 && (nssLow - lastRise) != 2 * CLK_DIV) periodErr++;
          lastRise = nssLow;
        end
        if (!sck && prevSck) begin
          if (misoIdx >= 0) begin
            miso = misoWord[misoIdx];
            misoIdx--;
          end else begin
            miso = 1'b1;
          end
        end
`ifndef SPI_MASTER_CMD_FIFO_EN
        if (cmdReady) readyHigh++;
`endif
      end
      if (nss && !prevNss) begin
        lastNssRiseCyc = cyc;
        if (inFrame) begin
          check("sck_rising_edges", monRise, 32);
          check("nss_low_cycles", nssLow, NSS_LOW);
          check("sck_period_errors", periodErr, 0);
          check("ready_high_in_frame", readyHigh, 0);
          check("busy_at_frame_end", busy, 1);
          check("mosi_after_frame", mosi, 0);
          if (expFrameQ.size() == 0) begin
            check("unexpected_frame", capFrame, 32'hDEAD_BEEF);
          end else begin
            check("mosi_frame", capFrame, expFrameQ.pop_front());
          end
          haveGap = 1;
        end
        inFrame = 0;
        monRise = 0;
        gapCnt  = 0;
      end
      if (nss) gapCnt++;
    end
    prevNss = nss;
    prevSck = sck;
  end

  logic prevNssR = 1'b1;
  logic prevRv   = 1'b0;

  // Response monitor: score each o_RspValid pulse against the expected sample.
  always @(negedge clk) begin
    if (!rst && rspValid) begin
      check("rsp_single_cycle", prevRv, 0);
      check("rsp_after_nss_rise", {prevNssR, nss}, 2'b01);
      if (expRspQ.size() == 0) begin
        check("unexpected_rsp", rspSample, 32'hDEAD_BEEF);
      end else begin
        check("rsp_sample", rspSample, expRspQ.pop_front());
      end
    end
    prevNssR = nss;
    prevRv   = rspValid;
  end

  // Hold a command valid and stable until accepted; called at posedge+1.
  task automatic sendCmd(input int idx);
    bit acc = 0;
    cmdValid = 1'b1;
    cmdReg   = vReg[idx];
    cmdVal   = vVal[idx];
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (cmdReady) begin
        acc = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    cmdValid = 1'b0;
    check("cmd_accepted", acc, 1);
    if (acc) begin
      expFrameQ.push_back(vFrame[idx]);
      expRspQ.push_back(vMiso[idx]);
      misoQ.push_back({vMiso[idx], 16'hFFFF});
    end
  endtask

  // Wait for o_Busy to drop, then check drain timing and empty scoreboards.
  task automatic waitIdle();
    bit done = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1;
        break;
      end
    end
    #1;
    check("idle_reached", done, 1);
    if (done) check("busy_drop_after_gap", cyc - lastNssRiseCyc, CS_GAP);
    check("frames_outstanding", expFrameQ.size(), 0);
    check("rsp_outstanding", expRspQ.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit hit = 0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_nss", nss, 1);
    check("reset_sck", sck, 0);
    check("reset_mosi", mosi, 0);
    check("reset_rsp_valid", rspValid, 0);
    check("reset_rsp_sample", rspSample, 0);
    check("reset_busy", busy, 0);
    check("reset_cmd_ready", cmdReady, 1);
    @(posedge clk);
    #1;

    // Single frames: voice-op write, then sine-table write.
    sendCmd(0);
    waitIdle();
    sendCmd(1);
    waitIdle();

    // Back-to-back burst, commands held valid while the master is busy.
    for (int k = 2; k < NV; k++) sendCmd(k);
    sendCmd(0);
    sendCmd(1);
`ifdef SPI_MASTER_CMD_FIFO_EN
    @(negedge clk);
    check("fifo_full_ready_low", cmdReady, 0);
`endif
    waitIdle();

    // Reset on the 10th SCK rising edge of a frame.
    sendCmd(2);
    for (int i = 0; i < TIMEOUT; i++) begin
      @(posedge clk);
      #1;
      if (monRise >= 10) begin
        hit = 1;
        break;
      end
    end
    check("reached_sck_edge10", hit, 1);
    rst = 1'b1;
    if (expFrameQ.size() > 0) void'(expFrameQ.pop_back());
    if (expRspQ.size() > 0) void'(expRspQ.pop_back());
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midreset_nss", nss, 1);
    check("midreset_sck", sck, 0);
    check("midreset_mosi", mosi, 0);
    check("midreset_rsp_valid", rspValid, 0);
    repeat (3) @(negedge clk);
    check("midreset_busy", busy, 0);
    check("midreset_ready", cmdReady, 1);
    @(posedge clk);
    #1;

    // Recovery frame after reset must be complete and correct.
    sendCmd(0);
    waitIdle();
    repeat (20) @(negedge clk);
    check("final_nss_idle", nss, 1);
    check("final_sck_idle", sck, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
